// File: rtl/timer_seq_pkg.sv
//------------------------------------------------------------------------------
// Module      : timer_seq_pkg
// Description : Register map offsets, timer compare offset and FSM state
//               encoding shared by the timer sequencer files.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package timer_seq_pkg;

  // Slave register map (byte offsets)
  localparam logic [7:0] c_seq_ctrl_ofs   = 8'h00;
  localparam logic [7:0] c_seq_idx_ofs    = 8'h04;
  localparam logic [7:0] c_table_base_ofs = 8'h40;

  // Timer compare register written through the master port
  localparam logic [7:0] c_timer_cmpo_ofs = 8'h04;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_CMPO = 2'd1,
    ST_WAIT_OF = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/timer_seq_table.sv
//------------------------------------------------------------------------------
// Module      : seq_table
// Description : DEPTH x 32 compare-value register file. One synchronous write
//               port, two combinational read ports (bus read and fetch).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_table #(
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] bus_raddr,
  output logic [31:0]   bus_rdata,
  input  logic [AW-1:0] fetch_raddr,
  output logic [31:0]   fetch_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Storage: cleared on reset, one entry written per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign bus_rdata   = r_mem[bus_raddr];
  assign fetch_rdata = r_mem[fetch_raddr];

endmodule

`default_nettype wire

// File: rtl/timer_seq.sv
//------------------------------------------------------------------------------
// Module      : timer_seq
// Description : Compare-value sequencer. Walks a table of compare values and
//               writes one into the timer's compare register after each timer
//               overflow, optionally looping, with a done interrupt.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_seq
  import timer_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic [7:0]  raddr_i,
  input  logic        rd_i,
  output logic [31:0] data_o,
  output logic [7:0]  tmr_waddr_o,
  output logic [31:0] tmr_data_o,
  output logic [3:0]  tmr_sel_o,
  output logic        tmr_we_o,
  input  logic        irq_timer_of_i,
  output logic        irq_seq_o
);

  localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_last_max = 4'(DEPTH - 1);

  seq_state_t  r_state;
  logic [3:0]  r_idx;
  logic        r_run;
  logic        r_loop;
  logic        r_irq_en;
  logic        r_done;
  logic        r_miss;
  logic [3:0]  r_len_m1;

  logic        w_busy;
  logic        w_wr_ctrl;
  logic        w_wr_tbl;
  logic        w_rd_tbl;
  logic [3:0]  w_last;
  logic        w_start;
  logic        w_abort;
  logic        w_of_adv;
  logic        w_more;
  logic        w_fetch_go;
  logic        w_done_set;
  logic        w_miss_set;
  logic [3:0]  w_next_idx;
  logic [31:0] w_tbl_bus_rdata;
  logic [31:0] w_tbl_fetch_rdata;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Byte enables are not supported; every write is a full word.
  assign w_unused  = ^{sel_i, w_next_idx};

  assign tmr_sel_o = 4'hF;
  assign w_busy    = (r_state != ST_IDLE);

  // Address decode; table offsets must be word aligned and below DEPTH
  assign w_wr_ctrl = we_i && (waddr_i == c_seq_ctrl_ofs);
  assign w_wr_tbl  = we_i && (waddr_i[7:6] == c_table_base_ofs[7:6]) &&
                     (waddr_i[1:0] == 2'b00) &&
                     ({1'b0, waddr_i[5:2]} < 5'(DEPTH));
  assign w_rd_tbl  = (raddr_i[7:6] == c_table_base_ofs[7:6]) &&
                     (raddr_i[1:0] == 2'b00) &&
                     ({1'b0, raddr_i[5:2]} < 5'(DEPTH));

  // Last table index actually used, saturated to the table size
  assign w_last     = (r_len_m1 > c_last_max) ? c_last_max : r_len_m1;

  assign w_start    = w_wr_ctrl && data_i[0] && !w_busy;
  assign w_abort    = w_wr_ctrl && !data_i[0] && w_busy;
  assign w_of_adv   = (r_state == ST_WAIT_OF) && irq_timer_of_i && !w_abort;
  assign w_more     = (r_idx < w_last);
  assign w_fetch_go = w_start || (w_of_adv && (w_more || r_loop));
  assign w_done_set = (r_state == ST_DONE) && !w_abort;
  assign w_miss_set = irq_timer_of_i && w_busy && (r_state != ST_WAIT_OF);

  // Index of the entry the next compare write will carry
  always_comb begin
    w_next_idx = r_idx;
    if (w_start) begin
      w_next_idx = 4'd0;
    end else if (w_of_adv) begin
      w_next_idx = w_more ? (r_idx + 4'd1) : 4'd0;
    end
  end

  seq_table #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (w_wr_tbl),
    .waddr       (waddr_i[AW+1:2]),
    .wdata       (data_i),
    .bus_raddr   (raddr_i[AW+1:2]),
    .bus_rdata   (w_tbl_bus_rdata),
    .fetch_raddr (w_next_idx[AW-1:0]),
    .fetch_rdata (w_tbl_fetch_rdata)
  );

  // Sequencer FSM; master write is launched on entry to WR_CMPO so it is
  // visible exactly while the FSM sits in WR_CMPO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 4'd0;
      tmr_we_o    <= 1'b0;
      tmr_waddr_o <= 8'h00;
      tmr_data_o  <= 32'h0;
      irq_seq_o   <= 1'b0;
    end else begin
      tmr_we_o    <= 1'b0;
      tmr_waddr_o <= 8'h00;
      tmr_data_o  <= 32'h0;
      irq_seq_o   <= 1'b0;
      if (w_fetch_go) begin
        tmr_we_o    <= 1'b1;
        tmr_waddr_o <= c_timer_cmpo_ofs;
        tmr_data_o  <= w_tbl_fetch_rdata;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_idx   <= 4'd0;
            r_state <= ST_WR_CMPO;
          end
        end
        ST_WR_CMPO: begin
          r_state <= w_abort ? ST_IDLE : ST_WAIT_OF;
        end
        ST_WAIT_OF: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (w_of_adv) begin
            if (w_fetch_go) begin
              r_idx   <= w_next_idx;
              r_state <= ST_WR_CMPO;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          irq_seq_o <= r_irq_en && !w_abort;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // SEQ_CTRL fields; hardware set/clear takes priority over the slave write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_loop   <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_miss   <= 1'b0;
      r_len_m1 <= 4'd0;
    end else begin
      if (w_wr_ctrl) begin
        r_run    <= data_i[0];
        r_loop   <= data_i[1];
        r_irq_en <= data_i[4];
        r_len_m1 <= data_i[11:8];
        if (data_i[3]) r_done <= 1'b0;
        if (data_i[5]) r_miss <= 1'b0;
      end
      if (w_done_set) begin
        r_done <= 1'b1;
        r_run  <= 1'b0;
      end
      if (w_miss_set) begin
        r_miss <= 1'b1;
      end
    end
  end

  // Read data mux; unmapped offsets return zero
  always_comb begin
    w_rdata = 32'h0;
    if (raddr_i == c_seq_ctrl_ofs) begin
      w_rdata = {20'h0, r_len_m1, 2'b00, r_miss, r_irq_en, r_done, w_busy,
                 r_loop, r_run};
    end else if (raddr_i == c_seq_idx_ofs) begin
      w_rdata = {28'h0, r_idx};
    end else if (w_rd_tbl) begin
      w_rdata = w_tbl_bus_rdata;
    end
  end

  // Registered read data, held while no read is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o <= 32'h0;
    end else if (rd_i) begin
      data_o <= w_rdata;
    end
  end

endmodule

`default_nettype wire

// File: doc/timer_seq.md
TIMER_SEQ -- requirements
Module: timer_seq

Interface
REQ-001 Parameter: DEPTH, 8, number of compare-table entries (power of two, 2..16).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 waddr_i  in  8  slave write byte offset.
REQ-006 data_i  in  32  slave write data.
REQ-007 sel_i  in  4  byte select; ignored, full-word writes only.
REQ-008 we_i  in  1  slave write strobe.
REQ-009 raddr_i  in  8  slave read byte offset.
REQ-010 rd_i  in  1  slave read strobe.
REQ-011 data_o  out  32  slave read data, registered.
REQ-012 tmr_waddr_o  out  8  master write offset to the timer.
REQ-013 tmr_data_o  out  32  master write data to the timer.
REQ-014 tmr_sel_o  out  4  master byte select, constant 4'hF.
REQ-015 tmr_we_o  out  1  master write strobe, one-cycle pulse.
REQ-016 irq_timer_of_i  in  1  timer overflow pulse.
REQ-017 irq_seq_o  out  1  one-cycle sequence-done interrupt.

Function
REQ-018 SEQ_CTRL at 0x00: [0] RW run; [1] RW loop; [2] RO busy; [3] W1C done; [4] RW irq_en; [5] W1C miss; [11:8] RW len_m1 (entries used = len_m1+1, saturated to DEPTH); all other bits read 0.
REQ-019 SEQ_IDX at 0x04: RO, current table index in [3:0]; other bits read 0.
REQ-020 TABLE at 0x40+4*i, i<DEPTH: RW {cmpo1,cmpo0}; offsets at or beyond DEPTH are ignored on write and read 0.
REQ-021 Reads: data_o updates one cycle after rd_i; it holds its value when rd_i=0; unmapped offsets read 0.
REQ-022 FSM states: IDLE, WR_CMPO, WAIT_OF, DONE.
REQ-023 IDLE: a SEQ_CTRL write with [0]=1 sets idx=0 and moves to WR_CMPO next cycle.
REQ-024 WR_CMPO: for exactly one cycle, tmr_we_o=1, tmr_waddr_o=8'h04 and tmr_data_o=TABLE[idx]; next state is WAIT_OF.
REQ-025 WAIT_OF, on irq_timer_of_i=1 with idx<len_m1: idx increments and the FSM moves to WR_CMPO.
REQ-026 WAIT_OF, on irq_timer_of_i=1 with idx==len_m1: if loop=1, idx is set to 0 and the FSM moves to WR_CMPO; otherwise the FSM moves to DONE.
REQ-027 DONE, lasting one cycle: sets done=1, pulses irq_seq_o=irq_en, clears run, and returns to IDLE.
REQ-028 busy=1 in every state except IDLE.
REQ-029 irq_timer_of_i pulses in IDLE, WR_CMPO or DONE are dropped; if busy, such a pulse sets miss=1.
REQ-030 A SEQ_CTRL write with [0]=0 while busy aborts: the FSM goes to IDLE next cycle, no further tmr_we_o is issued, and done is not set.
REQ-031 A SEQ_CTRL write with [0]=1 while busy does not restart; loop, irq_en and len_m1 update immediately.
REQ-032 TABLE writes while busy are allowed and take effect at the next WR_CMPO fetch.
REQ-033 When a slave write and a hardware set of the same flag fall in the same cycle, the hardware set wins.
REQ-034 tmr_waddr_o and tmr_data_o are 0 whenever tmr_we_o=0.

Reset
REQ-035 rst_n low: FSM=IDLE; idx=0; run, loop, irq_en, done and miss =0; len_m1=0; data_o=0; tmr_we_o=0; irq_seq_o=0; TABLE all 0.
REQ-036 Reset asserted mid-sequence aborts immediately with no partial master write.

Structure
REQ-037 Shared package holds the SEQ_CTRL, SEQ_IDX and TABLE base offsets, the timer TIMER_CMPO offset (8'h04), and the FSM state encoding.
REQ-038 One sub-module, seq_table: a DEPTH x 32 register file with one write port and two combinational read ports (bus read, fetch).

Verification
REQ-039 TABLE[0..2]={0x0030_0010,0x0060_0020,0x0090_0040}; SEQ_CTRL=0x201; three overflow pulses -> three master writes to 0x04 carrying those values in order, then done=1 and busy=0.
REQ-040 Same setup plus loop=1 and five overflow pulses -> write data sequence idx 0,1,2,0,1,2 and done stays 0.
REQ-041 irq_en=1, len_m1=0, one overflow pulse -> irq_seq_o high for exactly one cycle, two cycles after the pulse.
REQ-042 Run write with [0]=0 during WAIT_OF -> busy=0 next cycle, no tmr_we_o afterwards, done=0.
REQ-043 Overflow pulse in the WR_CMPO cycle -> miss=1 and idx unchanged; a W1C write of 0x20 clears miss.
REQ-044 rst_n pulsed low during WAIT_OF with idx=2 -> all REQ-035 values hold; a following overflow pulse causes no master write.
